// File: rtl/mem_port_sched_pkg.sv
// Shared definitions for the memory port scheduler: access sizes, FSM states,
// and the byte-enable generator used by the lane aligner.
package mem_port_sched_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_IF_BUS,
    ST_DM_BUS,
    ST_IF_RESP,
    ST_DM_RESP
  } state_e;

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: byte_en = 4'b0001 << lo;
      SZ_HALF: byte_en = lo[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/mem_port_sched_lane.sv
// Combinational lane aligner: byte enables, store-data replication,
// load lane extraction with sign/zero extension, and access legality.
module mem_lane_align
  import mem_port_sched_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        rd,
  input  logic        wr,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        illegal
);

  logic signed [7:0]  ld_b;
  logic signed [15:0] ld_h;

  always_comb begin
    be        = byte_en(size, addr_lo);
    ld_b      = rdata[{addr_lo, 3'b000} +: 8];
    ld_h      = rdata[{addr_lo[1], 4'b0000} +: 16];
    wdata_rep = wdata;
    rdata_ext = rdata;
    case (size)
      SZ_BYTE: begin
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = sign_ext ? 32'(ld_b) : {24'd0, ld_b};
      end
      SZ_HALF: begin
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = sign_ext ? 32'(ld_h) : {16'd0, ld_h};
      end
      default: ;
    endcase
    illegal = (rd & wr) || (size == 2'b11)
           || (size == SZ_HALF && addr_lo[0])
           || (size == SZ_WORD && addr_lo != 2'b00);
  end

endmodule

// File: rtl/mem_port_sched.sv
// Single-port memory scheduler arbitrating fetch and data access onto one bus.
// Optional bus timeout is enabled by defining MEM_TIMEOUT_EN.
module mem_port_sched
  import mem_port_sched_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  output logic        if_stall,
  input  logic        dm_read,
  input  logic        dm_write,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [1:0]  dm_size,
  input  logic        dm_signed,
  output logic [31:0] dm_rdata,
  output logic        dm_done,
  output logic        dm_err,
  output logic        dm_stall,
  output logic        if_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  state_e      state;
  logic        last_dm;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] lane_rdata;
  logic        lane_illegal;
  logic        dm_pend;
  logic        dm_wins;

  mem_lane_align u_align (
    .size      (dm_size),
    .addr_lo   (dm_addr[1:0]),
    .rd        (dm_read),
    .wr        (dm_write),
    .sign_ext  (dm_signed),
    .wdata     (dm_wdata),
    .rdata     (mem_rdata),
    .be        (lane_be),
    .wdata_rep (lane_wdata),
    .rdata_ext (lane_rdata),
    .illegal   (lane_illegal)
  );

  // Data normally wins, but a data grant followed by a pending fetch yields to IF.
  assign dm_pend  = dm_read | dm_write;
  assign dm_wins  = dm_pend & ~(last_dm & if_req);
  assign if_stall = if_req & ~if_done;
  assign dm_stall = dm_pend & ~dm_done;

`ifdef MEM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;
  assign tmo_hit = (tmo_cnt == TMO_LAST);
`else
  logic tmo_unused;
  assign tmo_unused = ^TIMEOUT_CYCLES;
  assign if_err     = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      last_dm   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      if_done   <= 1'b0;
      dm_rdata  <= '0;
      dm_done   <= 1'b0;
      dm_err    <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      if_err    <= 1'b0;
      tmo_cnt   <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
`ifdef MEM_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
          if (dm_wins) begin
            last_dm <= 1'b1;
            if (lane_illegal) begin
              dm_done  <= 1'b1;
              dm_err   <= 1'b1;
              dm_rdata <= '0;
              state    <= ST_DM_RESP;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= dm_write;
              mem_addr  <= dm_addr & ~32'h3;
              mem_be    <= lane_be;
              mem_wdata <= dm_write ? lane_wdata : '0;
              state     <= ST_DM_BUS;
            end
          end else if (if_req) begin
            last_dm   <= 1'b0;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr & ~32'h3;
            mem_be    <= 4'b1111;
            mem_wdata <= '0;
            state     <= ST_IF_BUS;
          end
        end
        ST_IF_BUS: begin
          if (mem_ack) begin
            mem_req  <= 1'b0;
            if_rdata <= mem_rdata;
            if_done  <= 1'b1;
            state    <= ST_IF_RESP;
          end
`ifdef MEM_TIMEOUT_EN
          else if (tmo_hit) begin
            mem_req  <= 1'b0;
            if_rdata <= '0;
            if_err   <= 1'b1;
            if_done  <= 1'b1;
            state    <= ST_IF_RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        ST_DM_BUS: begin
          if (mem_ack) begin
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            dm_rdata <= mem_we ? '0 : lane_rdata;
            dm_done  <= 1'b1;
            state    <= ST_DM_RESP;
          end
`ifdef MEM_TIMEOUT_EN
          else if (tmo_hit) begin
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            dm_rdata <= '0;
            dm_err   <= 1'b1;
            dm_done  <= 1'b1;
            state    <= ST_DM_RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        ST_IF_RESP: begin
          if_done  <= 1'b0;
          if_rdata <= '0;
`ifdef MEM_TIMEOUT_EN
          if_err   <= 1'b0;
`endif
          state    <= ST_IDLE;
        end
        ST_DM_RESP: begin
          dm_done  <= 1'b0;
          dm_err   <= 1'b0;
          dm_rdata <= '0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_port_sched.md
# mem_port_sched

Single-port memory scheduler for the 32I core. Shares one unified memory bus between instruction fetch (IF) and data access (MEM stage, driven by the decoded mem_read/mem_write/inst_size/is_signed controls). It sequences each bus transaction, generates byte lanes, extends load data, and stalls the losing requester.

## Interface
Parameters:
- TIMEOUT_CYCLES, 64: cycles without mem_ack before abort; only used with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  core clock, all state on rising edge
- reset  in  1  asynchronous, active-low
- if_req  in  1  fetch request, held until if_done
- if_addr  in  32  fetch address, word-aligned
- if_rdata  out  32  fetched word, valid with if_done
- if_done  out  1  one-cycle completion pulse
- if_stall  out  1  if_req & ~if_done
- dm_read / dm_write  in  1 each  data load / store request, held until dm_done
- dm_addr  in  32  byte address
- dm_wdata  in  32  store data, low bits significant
- dm_size  in  2  BYTE/HALF/WORD (shared package)
- dm_signed  in  1  1 = sign-extend load
- dm_rdata  out  32  extended load data, valid with dm_done
- dm_done  out  1  one-cycle completion pulse
- dm_err  out  1  qualifies dm_done: misaligned, read+write, or timeout
- dm_stall  out  1  (dm_read|dm_write) & ~dm_done
- if_err  out  1  qualifies if_done: timeout only
- mem_req  out  1  bus request, registered
- mem_we  out  1  write strobe
- mem_addr  out  32  word address ({addr[31:2],2'b00})
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_rdata  in  32  read data, sampled on mem_ack
- mem_ack  in  1  completes the transaction in the cycle it is high with mem_req

## Operation
- States: IDLE, IF_BUS, DM_BUS, IF_RESP, DM_RESP.
- IDLE: data pending and legal -> DM_BUS; data pending and illegal -> DM_RESP with dm_err=1, no bus cycle; else if_req -> IF_BUS.
- Priority: data over fetch, except when the previous grant was data and if_req is pending, in which case IF wins. Prevents back-to-back data starving fetch.
- x_BUS: mem_req=1, address/be/we/wdata held stable. On mem_ack, latch mem_rdata -> x_RESP.
- x_RESP: x_done=1 for one cycle -> IDLE. The requester drops or changes its request in the next cycle. A request is not re-granted in the cycle after its done.
- Byte lanes: BYTE be=1<<addr[1:0], wdata={4{b}}. HALF be=addr[1]?4'b1100:4'b0011, wdata={2{h}}. WORD be=4'b1111.
- Illegal: HALF with addr[0]=1; WORD with addr[1:0]!=0; dm_read&dm_write; dm_size=2'b11. Each gives dm_err=1 and dm_rdata=0.
- Load extension: select the lane by addr, then sign- or zero-extend to 32 per dm_signed. WORD passes through.
- Store done: dm_rdata=0.

## Timing
- Reset (async): state IDLE, all outputs 0, arbitration history = IF-last. A mem_ack arriving after reset is ignored.
- Latency: request seen in IDLE at cycle T, mem_req high at T+1, ack at T+1+w, done at T+2+w. Minimum 2 cycles.
- Misaligned data access: done+err at T+1.
- mem_ack outside x_BUS is ignored.
- Simultaneous if_req and data request in IDLE resolve by the priority rule. The loser's stall stays high.

## Configuration
- MEM_TIMEOUT_EN defined: a counter runs in x_BUS and clears on entry. When it reaches TIMEOUT_CYCLES, mem_req drops and the FSM goes to x_RESP with x_err=1 and rdata=0.
- Not defined: no counter, x_BUS waits indefinitely, and if_err is tied to 0.

## Structure
- Shared package: size encodings BYTE=2'd0, HALF=2'd1, WORD=2'd2; state encoding; byte-enable function.
- Sub-module mem_lane_align: combinational be/wdata generation, load extraction and extension, and legality check.

## Test plan
- Fetch only: if_req, addr 0x100, ack one cycle later with rdata 0x00500093 -> if_done at T+2 with if_rdata=0x00500093, mem_be=4'b1111.
- Load byte: dm_read, addr 0x203, BYTE, signed, mem_rdata 0x80xxxxxx -> mem_be=4'b1000, dm_rdata=0xFFFFFF80. Same access unsigned -> 0x00000080.
- Store half: dm_write, addr 0x12, HALF, wdata 0xABCD -> mem_be=4'b1100, mem_wdata=0xABCDABCD, mem_we=1.
- Contention: if_req and dm_read together, then a second dm_read -> order DM, IF, DM. Stalls stay high until each respective done.
- Misaligned: WORD at 0x102 -> no mem_req, dm_done&dm_err at T+1. Reset asserted during DM_BUS -> mem_req=0 immediately, IDLE after release.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4: never ack -> mem_req drops after 4 cycles, if_done&if_err.
